fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_queue.sv | 57 +++++
 rtl/fetch_ctrl.sv | 105 ++++++++++
 tb/tb_fetch_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        END  = 2'd2
    } fetch_state_t;

    localparam logic [7:0] PC_INC = 8'd4;

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: circular buffer of fetched {pc, instr} entries with flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter int PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
    parameter int CNT_W  = $clog2(QDEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     push_entry,
    output logic             valid,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [QDEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign valid   = (count != '0);
    assign do_pop  = pop & valid & ~flush;
    assign do_push = push & ~flush;
    assign head    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // When full, push and pop share the head slot: it is read out this cycle
    // and rewritten as the new tail, so ordering is preserved.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: BOOT/RUN/END sequencer, fetch PC and prefetch queue.
// Optional performance counters are enabled with `define FETCH_CTRL_PERF_EN.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int MEM_BYTES = 64,
    parameter int QDEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [7:0]  imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        branch_valid,
    input  logic [7:0]  branch_target,
    input  logic        stall,
`ifdef FETCH_CTRL_PERF_EN
    output logic [15:0] perf_fetch_cnt,
    output logic [15:0] perf_stall_cnt,
`endif
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [7:0]  if_pc
);

    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(QDEPTH);
    localparam logic [8:0]       MEM_LIMIT = 9'(MEM_BYTES);

    fetch_state_t     state;
    logic [7:0]       fetch_pc;
    logic [CNT_W-1:0] q_count;
    logic             pop;
    logic             push;
    logic             flush;
    logic [7:0]       tgt_aligned;
    logic             tgt_in_mem;
    logic             next_past_end;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign imem_addr     = fetch_pc;
    assign pop           = if_valid & ~stall;
    assign flush         = branch_valid & (state != BOOT);
    assign push          = (state == RUN) & ~branch_valid & ((q_count < DEPTH_C) | pop);
    assign tgt_aligned   = {branch_target[7:2], 2'b00};
    assign tgt_in_mem    = ({1'b0, tgt_aligned} < MEM_LIMIT);
    // Nine-bit sum so a 256-byte memory still detects its end instead of wrapping.
    assign next_past_end = (({1'b0, fetch_pc} + {1'b0, PC_INC}) >= MEM_LIMIT);
    assign push_entry    = '{pc: fetch_pc, instr: imem_instr};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= BOOT;
            fetch_pc <= '0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN, END: begin
                    if (branch_valid) begin
                        fetch_pc <= tgt_aligned;
                        state    <= tgt_in_mem ? RUN : END;
                    end else if (push) begin
                        fetch_pc <= fetch_pc + PC_INC;
                        if (next_past_end) state <= END;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .push_entry (push_entry),
        .valid      (if_valid),
        .head       (head),
        .count      (q_count)
    );

    assign if_instr = head.instr;
    assign if_pc    = head.pc;

`ifdef FETCH_CTRL_PERF_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (push)             perf_fetch_cnt <= sat_inc16(perf_fetch_cnt);
            if (if_valid & stall) perf_stall_cnt <= sat_inc16(perf_stall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a combinational memory returning 0xC0DE0000 | addr.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  imem_addr;
    logic [31:0] imem_instr;
    logic        branch_valid;
    logic [7:0]  branch_target;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [7:0]  if_pc;
`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] perf_fetch_cnt;
    logic [15:0] perf_stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign imem_instr = 32'hC0DE_0000 | {24'h0, imem_addr};

    fetch_ctrl #(
        .MEM_BYTES (64),
        .QDEPTH    (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .stall         (stall),
`ifdef FETCH_CTRL_PERF_EN
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        branch_valid = 1'b0;
        branch_target = 8'h00;
        stall        = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  exp_pc [4];
        logic [31:0] exp_in [4];
        exp_pc = '{8'h00, 8'h04, 8'h08, 8'h0C};
        exp_in = '{32'hC0DE0000, 32'hC0DE0004, 32'hC0DE0008, 32'hC0DE000C};

        reset = 1'b1;
        branch_valid = 1'b0;
        branch_target = 8'h00;
        stall = 1'b0;
        #1;
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_if_pc", 32'(if_pc), 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_imem_addr", 32'(imem_addr), 32'h0);

        // Straight-line fetch after reset release.
        step();
        step();
        reset = 1'b0;
        step();
        chk("boot_no_valid", 32'(if_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("run_valid", 32'(if_valid), 32'h1);
            chk("run_pc", 32'(if_pc), 32'(exp_pc[i]));
            chk("run_instr", if_instr, exp_in[i]);
        end

        // Stall fills the queue, then drains in order.
        do_reset();
        step();
        step();
        chk("st_first_pc", 32'(if_pc), 32'h00);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("st_imem_hold", 32'(imem_addr), 32'h08);
        chk("st_head_pc", 32'(if_pc), 32'h00);
        chk("st_head_valid", 32'(if_valid), 32'h1);
        stall = 1'b0;
        step();
        chk("st_drain1", 32'(if_pc), 32'h04);
        step();
        chk("st_drain2", 32'(if_pc), 32'h08);
        step();
        chk("st_drain3", 32'(if_pc), 32'h0C);

        // Branch flushes a full, stalled queue.
        stall = 1'b1;
        step();
        chk("br_full_pc", 32'(if_pc), 32'h0C);
        chk("br_full_imem", 32'(imem_addr), 32'h14);
        branch_valid = 1'b1;
        branch_target = 8'h22;
        step();
        branch_valid = 1'b0;
        chk("br_flush_valid", 32'(if_valid), 32'h0);
        chk("br_flush_imem", 32'(imem_addr), 32'h20);
        chk("br_flush_pc", 32'(if_pc), 32'h0);
        chk("br_flush_instr", if_instr, 32'h0);
        step();
        chk("br_tgt_valid", 32'(if_valid), 32'h1);
        chk("br_tgt_pc", 32'(if_pc), 32'h20);
        chk("br_tgt_instr", if_instr, 32'hC0DE0020);
        stall = 1'b0;

        // Free-running fetch to the end of memory.
        do_reset();
        step();
        for (int k = 0; k < 16; k++) begin
            step();
            chk("end_run_pc", 32'(if_pc), 32'(k * 4));
        end
        chk("end_imem", 32'(imem_addr), 32'h40);
`ifdef FETCH_CTRL_PERF_EN
        chk("perf_fetch", 32'(perf_fetch_cnt), 32'd16);
        chk("perf_stall", 32'(perf_stall_cnt), 32'd0);
`endif
        for (int k = 0; k < 4; k++) begin
            step();
            chk("end_idle_valid", 32'(if_valid), 32'h0);
            chk("end_idle_imem", 32'(imem_addr), 32'h40);
        end

        // Branch out of range stays in END; in-range branch resumes.
        branch_valid = 1'b1;
        branch_target = 8'h50;
        step();
        branch_valid = 1'b0;
        chk("oor_imem", 32'(imem_addr), 32'h50);
        chk("oor_valid", 32'(if_valid), 32'h0);
        step();
        chk("oor_still_idle", 32'(if_valid), 32'h0);
        chk("oor_imem_hold", 32'(imem_addr), 32'h50);
        branch_valid = 1'b1;
        branch_target = 8'h10;
        step();
        branch_valid = 1'b0;
        chk("resume_imem", 32'(imem_addr), 32'h10);
        chk("resume_valid0", 32'(if_valid), 32'h0);
        step();
        chk("resume_valid", 32'(if_valid), 32'h1);
        chk("resume_pc", 32'(if_pc), 32'h10);
        chk("resume_instr", if_instr, 32'hC0DE0010);

        // Asynchronous reset mid-stream with a full queue.
        do_reset();
        step();
        step();
        stall = 1'b1;
        step();
        step();
        chk("ar_full_imem", 32'(imem_addr), 32'h08);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", 32'(if_valid), 32'h0);
        chk("ar_pc", 32'(if_pc), 32'h0);
        chk("ar_imem", 32'(imem_addr), 32'h0);
        stall = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        chk("ar_boot_valid", 32'(if_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ar_run_pc", 32'(if_pc), 32'(exp_pc[i]));
            chk("ar_run_instr", if_instr, exp_in[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
